// File: rtl/ioctl_download_seq.sv
// rtl/ioctl_download_seq.sv - replays a valid/ready byte stream onto an hps_io-style ioctl download bus
// Optional IOCTL_CHECKSUM_EN adds a 16-bit running sum of written bytes on port checksum.
module ioctl_download_seq #(
  parameter int SETUP_CYCLES = 2,
  parameter int WR_GAP       = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  index,
  input  logic [24:0] length,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic        ioctl_download,
  output logic        ioctl_wr,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_dout,
  output logic [7:0]  ioctl_index,
  input  logic        ioctl_wait,
  output logic        busy,
`ifdef IOCTL_CHECKSUM_EN
  output logic        done,
  output logic [15:0] checksum
`else
  output logic        done
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_FETCH,
    S_WRITE,
    S_INC,
    S_GAP,
    S_TAIL,
    S_DONE
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'((WR_GAP > 0) ? (WR_GAP - 1) : 0);

  state_t      state_q;
  logic [15:0] timer_q;
  logic [24:0] length_q;
  logic [24:0] count_q;
  logic [24:0] addr_q;
  logic [7:0]  dout_q;
  logic [7:0]  index_q;
  logic        src_ready_q;
  logic        download_q;
  logic        wr_q;
  logic        busy_q;
  logic        done_q;

  logic [24:0] count_d;
  logic        last_byte;

  assign count_d   = count_q + 25'd1;
  assign last_byte = (count_d == length_q);

  assign src_ready      = src_ready_q;
  assign ioctl_download = download_q;
  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_index    = index_q;
  assign busy           = busy_q;
  assign done           = done_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      length_q    <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      index_q     <= '0;
      src_ready_q <= 1'b0;
      download_q  <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            index_q    <= index;
            length_q   <= length;
            count_q    <= '0;
            addr_q     <= '0;
            timer_q    <= '0;
            busy_q     <= 1'b1;
            download_q <= 1'b1;
            state_q    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (timer_q == SETUP_LAST) begin
            timer_q <= '0;
            if (length_q == 25'd0) begin
              state_q <= S_TAIL;
            end else begin
              src_ready_q <= 1'b1;
              state_q     <= S_FETCH;
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_FETCH: begin
          // Address moves only here so addr/dout stay put from the strobe to the next accept.
          if (src_valid && src_ready_q) begin
            dout_q      <= src_data;
            addr_q      <= count_q;
            src_ready_q <= 1'b0;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!ioctl_wait) begin
            wr_q    <= 1'b1;
            state_q <= S_INC;
          end
        end
        S_INC: begin
          count_q <= count_d;
          timer_q <= '0;
          if (last_byte) begin
            state_q <= S_TAIL;
          end else if (WR_GAP == 0) begin
            src_ready_q <= 1'b1;
            state_q     <= S_FETCH;
          end else begin
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (timer_q == GAP_LAST) begin
            timer_q     <= '0;
            src_ready_q <= 1'b1;
            state_q     <= S_FETCH;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_TAIL: begin
          // ioctl_wait is deliberately ignored here; the tail length is fixed.
          if (timer_q == SETUP_LAST) begin
            timer_q    <= '0;
            download_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef IOCTL_CHECKSUM_EN
  logic [15:0] csum_q;

  assign checksum = csum_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      csum_q <= '0;
    end else if (state_q == S_WRITE && !ioctl_wait) begin
      csum_q <= csum_q + {8'd0, dout_q};
    end
  end
`endif

endmodule

// File: tb/tb_ioctl_download_seq.sv
// tb/tb_ioctl_download_seq.sv - scoreboard bench for ioctl_download_seq with randomized frames
module tb_ioctl_download_seq;

  localparam int SETUP = 2;
  localparam int GAP   = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  index = 8'd0;
  logic [24:0] length = 25'd0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = 8'd0;
  logic        src_ready;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait = 1'b0;
  logic        busy;
  logic        done;
`ifdef IOCTL_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  ioctl_download_seq #(.SETUP_CYCLES(SETUP), .WR_GAP(GAP)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .index(index), .length(length),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .busy(busy),
`ifdef IOCTL_CHECKSUM_EN
    .done(done), .checksum(checksum)
`else
    .done(done)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [7:0]  idx;
  } wr_t;

  int total = 0;
  int bad = 0;
  wr_t exp_q[$];
  logic [7:0] src_q[$];
  int popped = 0;
  int stall_at = -1;
  int stall_left = 0;
  bit acc = 1'b0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr_cyc = 0;
  int dl_cyc = 0;
  int done_cnt = 0;
  bit check_timing = 1'b0;

  task automatic chk(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Source: presents queued bytes, optionally stalls before one of them, holds until accepted.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        src_q.delete();
        acc = 1'b0;
        src_valid = 1'b0;
      end else begin
        if (acc) begin
          void'(src_q.pop_front());
          popped++;
          src_valid = 1'b0;
        end
        if (!src_valid) begin
          src_data = 8'($urandom);
          if (popped == stall_at && stall_left > 0) stall_left--;
          else if (src_q.size() > 0) begin
            src_valid = 1'b1;
            src_data = src_q[0];
          end
        end
        acc = src_valid && src_ready;
      end
    end
  end

  // Monitor: pops the scoreboard on every write strobe and watches framing.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (!reset_n) begin
        exp_q.delete();
      end else begin
        if (ioctl_download) dl_cyc++;
        if (ioctl_wr) begin
          chk("wr_pending", longint'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", ioctl_addr, e.addr);
            chk("wr_data", ioctl_dout, e.data);
            chk("wr_index", ioctl_index, e.idx);
          end
          if (check_timing && wr_cnt > 0) chk("wr_spacing", cyc - last_wr_cyc, 3 + GAP);
          last_wr_cyc = cyc;
          wr_cnt++;
        end
        if (done) begin
          done_cnt++;
          chk("done_busy_low", busy, 0);
          chk("done_download_low", ioctl_download, 0);
        end
      end
    end
  end

  task automatic load_frame(input logic [7:0] idx, input logic [7:0] bytes[$], input int st_at,
                            input int st_len);
    wr_t e;
    stall_at = st_at;
    stall_left = st_len;
    popped = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      src_q.push_back(bytes[i]);
      e.addr = 25'(i);
      e.data = bytes[i];
      e.idx = idx;
      exp_q.push_back(e);
    end
    wr_cnt = 0;
    dl_cyc = 0;
    @(negedge clk_sys);
    start = 1'b1;
    index = idx;
    length = 25'(bytes.size());
    @(negedge clk_sys);
    start = 1'b0;
    index = 8'($urandom);
    length = 25'($urandom);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_frame(input logic [7:0] idx, input logic [7:0] bytes[$], input int st_at,
                           input int st_len, input int wait_on, input int restart_at,
                           input bit tail_wait, input bit coincide);
    int n;
    int sum;
    int d0;
    int budget;
    int w0;
    bit waited;
    bit restarted;
    n = bytes.size();
    sum = 0;
    for (int i = 0; i < n; i++) sum += int'(bytes[i]);
    check_timing = (st_len == 0) && (wait_on < 0);
    d0 = done_cnt;
    budget = 0;
    waited = 1'b0;
    restarted = 1'b0;
    load_frame(idx, bytes, st_at, st_len);
    while (!done && budget < 5000) begin
      if (wait_on >= 0 && !waited && wr_cnt == wait_on) begin
        waited = 1'b1;
        ioctl_wait = 1'b1;
        w0 = wr_cnt;
        repeat (10) @(negedge clk_sys);
        chk("wait_no_wr", wr_cnt, w0);
        chk("wait_addr", ioctl_addr, wait_on);
        chk("wait_dout", ioctl_dout, bytes[wait_on]);
        ioctl_wait = 1'b0;
        @(negedge clk_sys);
        chk("wr_after_wait", ioctl_wr, 1);
        budget += 11;
      end else if (restart_at >= 0 && !restarted && wr_cnt == restart_at) begin
        restarted = 1'b1;
        start = 1'b1;
        index = 8'h55;
        length = 25'd7;
        @(negedge clk_sys);
        start = 1'b0;
        budget++;
      end else begin
        if (tail_wait && wr_cnt == n) ioctl_wait = 1'b1;
        @(negedge clk_sys);
        budget++;
      end
    end
    chk("done_seen", done, 1);
    if (coincide) begin
      start = 1'b1;
      index = 8'h77;
      length = 25'd3;
      @(negedge clk_sys);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk("start_at_done_ignored", busy, 0);
        @(negedge clk_sys);
      end
    end
    ioctl_wait = 1'b0;
    chk("wr_count", wr_cnt, n);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_addr", ioctl_addr, (n > 0) ? n - 1 : 0);
    chk("index_held", ioctl_index, idx);
    if (check_timing) chk("download_cycles", dl_cyc, SETUP + 3 * n + GAP * ((n > 0) ? n - 1 : 0) + SETUP);
`ifdef IOCTL_CHECKSUM_EN
    chk("checksum", checksum, sum & 16'hFFFF);
`endif
    repeat (3) @(negedge clk_sys);
    chk("done_once", done_cnt - d0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_src_ready"}, src_ready, 0);
    chk({tag, "_download"}, ioctl_download, 0);
    chk({tag, "_wr"}, ioctl_wr, 0);
    chk({tag, "_addr"}, ioctl_addr, 0);
    chk({tag, "_dout"}, ioctl_dout, 0);
    chk({tag, "_index"}, ioctl_index, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef IOCTL_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  task automatic reset_mid_frame();
    logic [7:0] b[$];
    int d0;
    int budget;
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    check_timing = 1'b0;
    d0 = done_cnt;
    load_frame(8'hA5, b, -1, 0);
    budget = 0;
    while (wr_cnt < 2 && budget < 2000) begin
      @(negedge clk_sys);
      budget++;
    end
    chk("reset_reached_byte2", wr_cnt, 2);
    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    chk("no_done_after_reset", done_cnt - d0, 0);
  endtask

  initial begin
    logic [7:0] b[$];
    int n;
    int st_at;
    int st_len;
    int w_on;
    repeat (3) @(negedge clk_sys);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(8'h01, b, -1, 0, -1, -1, 1'b0, 1'b0);
    run_frame(8'h02, b, -1, 0, 1, -1, 1'b0, 1'b0);
    b.delete();
    run_frame(8'h03, b, -1, 0, -1, -1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) b.push_back(8'($urandom));
    run_frame(8'h04, b, 2, 7, -1, -1, 1'b0, 1'b0);
    b.delete();
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    run_frame(8'h3C, b, -1, 0, -1, 2, 1'b0, 1'b0);
    reset_mid_frame();
    run_frame(8'h06, b, -1, 0, -1, -1, 1'b0, 1'b0);
    b = '{8'hFF, 8'hFE, 8'h80};
    run_frame(8'h07, b, -1, 0, -1, -1, 1'b1, 1'b1);

    for (int f = 0; f < 8; f++) begin
      b.delete();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      st_at = -1;
      st_len = 0;
      w_on = -1;
      if ($urandom_range(0, 2) == 0) w_on = $urandom_range(0, n - 1);
      else if ($urandom_range(0, 1) == 1) begin
        st_at = $urandom_range(0, n - 1);
        st_len = $urandom_range(1, 8);
      end
      run_frame(8'($urandom), b, st_at, st_len, w_on, -1, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
